// File: rtl/retire_trace_buf.sv
// retire_trace_buf: captures retired instructions into a FIFO and drains them
// to a trace port over valid/ready; keeps retire/drop counts, freezes on ebreak.
//
// Ports:
//   i_clk, i_rst_n        clock, async active-low reset
//   i_retire_*            retire interface from the hart
//   o_trace_valid/ready   head-of-FIFO handshake; o_trace_* are head fields
//   o_level/full/empty    occupancy state
//   o_halted              ebreak captured, further retires ignored
//   o_retire_count        accepted retires (including drops)
//   o_drop_count          retires lost to a full FIFO (saturating)
module retire_trace_buf #(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_retire_valid,
    input  logic [31:0]   i_retire_inst,
    input  logic          i_retire_trap,
    input  logic          i_retire_halt,
    input  logic [4:0]    i_retire_rd_waddr,
    input  logic [31:0]   i_retire_rd_wdata,
    input  logic [31:0]   i_retire_pc,
    input  logic [31:0]   i_retire_next_pc,
    output logic          o_trace_valid,
    input  logic          i_trace_ready,
    output logic [31:0]   o_trace_inst,
    output logic [31:0]   o_trace_pc,
    output logic [31:0]   o_trace_next_pc,
    output logic [31:0]   o_trace_rd_wdata,
    output logic [4:0]    o_trace_rd_waddr,
    output logic [1:0]    o_trace_flags,
    output logic [AW:0]   o_level,
    output logic          o_full,
    output logic          o_empty,
    output logic          o_halted,
    output logic [31:0]   o_retire_count,
    output logic [15:0]   o_drop_count
);

    // {halt, trap, rd_waddr, rd_wdata, next_pc, pc, inst}
    localparam int EW = 135;
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [EW-1:0] mem_q [DEPTH];
    logic [EW-1:0] entry_in;
    logic [EW-1:0] head;

    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   level_q, level_d;
    logic          halted_q, halted_d;
    logic [31:0]   retire_cnt_q, retire_cnt_d;
    logic [15:0]   drop_cnt_q, drop_cnt_d;

    logic full, empty;
    logic accept, pop, push, drop;

    assign full   = (level_q == FULL_LVL);
    assign empty  = (level_q == '0);
    assign accept = i_retire_valid && !halted_q;
    assign pop    = !empty && i_trace_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still takes it.
    assign push   = accept && (!full || pop);
    assign drop   = accept && full && !pop;

    assign entry_in = {i_retire_halt, i_retire_trap, i_retire_rd_waddr,
                       i_retire_rd_wdata, i_retire_next_pc, i_retire_pc,
                       i_retire_inst};

    always_comb begin
        wptr_d       = wptr_q;
        rptr_d       = rptr_q;
        level_d      = level_q;
        halted_d     = halted_q;
        retire_cnt_d = retire_cnt_q;
        drop_cnt_d   = drop_cnt_q;

        if (push) wptr_d = wptr_q + AW'(1);
        if (pop)  rptr_d = rptr_q + AW'(1);

        unique case ({push, pop})
            2'b10:   level_d = level_q + (AW+1)'(1);
            2'b01:   level_d = level_q - (AW+1)'(1);
            default: level_d = level_q;
        endcase

        if (accept) retire_cnt_d = retire_cnt_q + 32'd1;
        if (drop && drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
        // Halt latches even when the ebreak packet itself is dropped.
        if (accept && i_retire_halt) halted_d = 1'b1;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wptr_q       <= '0;
            rptr_q       <= '0;
            level_q      <= '0;
            halted_q     <= 1'b0;
            retire_cnt_q <= '0;
            drop_cnt_q   <= '0;
        end else begin
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            level_q      <= level_d;
            halted_q     <= halted_d;
            retire_cnt_q <= retire_cnt_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    // Storage is not reset; the pointers/level make stale data invisible.
    always_ff @(posedge i_clk) begin
        if (push) mem_q[wptr_q] <= entry_in;
    end

    assign head = mem_q[rptr_q];

    assign o_trace_valid    = !empty;
    assign o_trace_inst     = head[31:0];
    assign o_trace_pc       = head[63:32];
    assign o_trace_next_pc  = head[95:64];
    assign o_trace_rd_wdata = head[127:96];
    assign o_trace_rd_waddr = head[132:128];
    assign o_trace_flags    = head[134:133];

    assign o_level        = level_q;
    assign o_full         = full;
    assign o_empty        = empty;
    assign o_halted       = halted_q;
    assign o_retire_count = retire_cnt_q;
    assign o_drop_count   = drop_cnt_q;

endmodule
